cordic_phase_gen: RTL and testbench
===================================

Name: cordic_phase_gen

Overview:
Upstream phase-accumulator stage that produces the 32-bit angle stream feeding the CORDIC sine/cosine core, one angle per clock. A burst or continuous run is started by command. A delayed valid tracks the CORDIC pipeline latency, so downstream logic knows when COSout/SINout correspond to a real angle. The block replaces ad-hoc angle stepping with a controlled, frequency-programmable sweep.

Parameters:
ANGLE_W, 32, angle width; full scale 2^32 = 360 deg, so 45 deg = 0x20000000
CNT_W, 16, burst counter width
LATENCY, 16, CORDIC core latency in clocks from angle in to COS/SIN out; legal range >= 1

Ports:
clk  input  1  system clock, rising edge
nreset  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
stop  input  1  end a run early; sampled only in RUN
freq_word  input  ANGLE_W  phase increment per clock; latched at start
phase_init  input  ANGLE_W  first angle of the run; latched at start
burst_len  input  CNT_W  number of angles to emit; 0 = continuous until stop
angle  output  ANGLE_W  angle to CORDIC core
angle_valid  output  1  angle is a live sample
out_valid  output  1  angle_valid delayed LATENCY clocks; qualifies CORDIC outputs
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse at end of run

Behaviour:
- One clock, clk. nreset is asynchronous and active-low. All state is clocked and asserts immediately on nreset low.
- Reset values: angle=0, angle_valid=0, out_valid=0, busy=0, done=0, state=IDLE, counters=0, valid delay line all 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start=1 at edge T:
  - fw_reg<=freq_word, angle<=phase_init, angle_valid<=1, cnt<=1, busy<=1, state<=RUN.
  - The first valid angle is visible in cycle T+1.
  - stop is ignored in IDLE, including when asserted together with start.
- RUN, each edge:
  - If stop=1, or (burst_len!=0 and cnt==burst_len): angle_valid<=0, angle holds, state<=DRAIN.
  - Otherwise: angle<=angle+fw_reg mod 2^ANGLE_W (wrap silently, no saturation), cnt<=cnt+1.
  - Exactly burst_len valid angles are emitted.
  - start is ignored in RUN. freq_word, phase_init and burst_len changes are ignored in RUN except burst_len, which is compared live; it must be held stable during a run.
- burst_len=0: continuous run; cnt wraps freely and never terminates the run.
- DRAIN:
  - drain counter loads LATENCY on entry and decrements each clock.
  - When it reaches 0: state<=IDLE, busy<=0, done<=1 for exactly one cycle.
  - start and stop are ignored in DRAIN.
- out_valid: shift register of depth LATENCY fed by angle_valid. out_valid equals angle_valid from LATENCY clocks earlier.
- Timing: if the last valid angle is in cycle L, the last out_valid high is in cycle L+LATENCY. done is high, and busy low, in cycle L+LATENCY+1.
- angle holds its last value whenever angle_valid=0.
- Reset mid-run: everything clears asynchronously; no done pulse is generated.

Test Plan:
- LATENCY=16, phase_init=0, freq_word=0x20000000, burst_len=8, start pulse -> angle 0x00000000, 0x20000000 ... 0xE0000000 on 8 consecutive valid cycles. angle_valid low afterwards. out_valid high 8 cycles starting 16 clocks after the first angle. done pulses 17 clocks after the last angle.
- Wrap: phase_init=0xF0000000, freq_word=0x20000000, burst_len=3 -> angles 0xF0000000, 0x10000000, 0x30000000.
- Continuous: burst_len=0, freq_word=0x00400000, stop asserted on the 6th RUN edge -> exactly 6 valid angles (0 through 0x01400000), then DRAIN, done after LATENCY+1.
- Mid-run changes: change freq_word to 0x1 and pulse start during RUN -> increment unchanged, no restart. start during DRAIN ignored. start asserted together with stop in IDLE starts a run.
- Reset: drop nreset during RUN and during DRAIN -> all outputs 0 immediately, no done pulse. A start after release behaves as the first scenario.
- Back-to-back: start asserted in the cycle done is high -> new run begins; first angle is valid the following cycle.

Source files
------------

// File: rtl/cordic_phase_gen_if.sv
// rtl/cordic_phase_gen_if.sv - command and angle-stream bundle between controller and phase generator
interface cordic_phase_gen_if #(
   parameter int ANGLE_W = 32,
   parameter int CNT_W   = 16
);
   logic               start;
   logic               stop;
   logic [ANGLE_W-1:0] freq_word;
   logic [ANGLE_W-1:0] phase_init;
   logic [CNT_W-1:0]   burst_len;
   logic [ANGLE_W-1:0] angle;
   logic               angle_valid;
   logic               out_valid;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, freq_word, phase_init, burst_len,
      input  angle, angle_valid, out_valid, busy, done
   );

   modport slave (
      input  start, stop, freq_word, phase_init, burst_len,
      output angle, angle_valid, out_valid, busy, done
   );
endinterface

// File: rtl/cordic_phase_gen.sv
// rtl/cordic_phase_gen.sv - phase-accumulator angle source for the CORDIC core
// Emits burst or continuous angle sweeps; out_valid tracks the CORDIC pipeline latency.
module cordic_phase_gen #(
   parameter int ANGLE_W = 32,
   parameter int CNT_W   = 16,
   parameter int LATENCY = 16
) (
   input logic               clk,
   input logic               nreset,
   cordic_phase_gen_if.slave pg
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DW = $clog2(LATENCY + 1);

   state_t             state_q, state_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic [ANGLE_W-1:0] fw_q, fw_d;
   logic               angle_valid_q, angle_valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]      drain_q, drain_d;
   logic [LATENCY-1:0] dly_q, dly_d;
   logic               done_q, done_d;
   logic               run_end;
   logic               drain_end;

   // burst_len is compared live, so it must stay stable for the whole run
   assign run_end   = pg.stop || ((pg.burst_len != '0) && (cnt_q == pg.burst_len));
   assign drain_end = (drain_q == DW'(1));

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pg.start) state_d = RUN;
         RUN:     if (run_end) state_d = DRAIN;
         DRAIN:   if (drain_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      angle_d       = angle_q;
      fw_d          = fw_q;
      angle_valid_d = angle_valid_q;
      cnt_d         = cnt_q;
      drain_d       = drain_q;
      done_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (pg.start) begin
               fw_d          = pg.freq_word;
               angle_d       = pg.phase_init;
               angle_valid_d = 1'b1;
               cnt_d         = CNT_W'(1);
            end
         end
         RUN: begin
            if (run_end) begin
               angle_valid_d = 1'b0;
               drain_d       = DW'(LATENCY);
            end else begin
               angle_d = angle_q + fw_q;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            drain_d = drain_q - DW'(1);
            done_d  = drain_end;
         end
         default: ;
      endcase
   end

   // Valid delay line: dly_q[LATENCY-1] is angle_valid from LATENCY clocks ago
   always_comb begin
      dly_d    = dly_q;
      dly_d[0] = angle_valid_q;
      for (int i = 1; i < LATENCY; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         angle_q       <= '0;
         fw_q          <= '0;
         angle_valid_q <= 1'b0;
         cnt_q         <= '0;
         drain_q       <= '0;
         dly_q         <= '0;
         done_q        <= 1'b0;
      end else begin
         angle_q       <= angle_d;
         fw_q          <= fw_d;
         angle_valid_q <= angle_valid_d;
         cnt_q         <= cnt_d;
         drain_q       <= drain_d;
         dly_q         <= dly_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      pg.busy        = (state_q == RUN) || (state_q == DRAIN);
      pg.angle       = angle_q;
      pg.angle_valid = angle_valid_q;
      pg.out_valid   = dly_q[LATENCY-1];
      pg.done        = done_q;
   end
endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb/tb_cordic_phase_gen.sv - directed bench with a run-level reference model for cordic_phase_gen
module tb_cordic_phase_gen;
   localparam int AW  = 32;
   localparam int CW  = 16;
   localparam int LAT = 16;
   localparam int BIG = 1 << 30;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   cordic_phase_gen_if #(.ANGLE_W(AW), .CNT_W(CW)) pg ();

   cordic_phase_gen #(.ANGLE_W(AW), .CNT_W(CW), .LATENCY(LAT)) dut (
      .clk    (clk),
      .nreset (nreset),
      .pg     (pg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Run-level model: a run is described by its first and last valid cycle
   int          cyc = 0;
   bit          m_have = 1'b0;
   int          m_first = 0;
   int          m_last = 0;
   logic [31:0] m_pi = '0;
   logic [31:0] m_fw = '0;
   logic [31:0] m_hold = '0;

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m_have = 1'b0;
         m_hold = '0;
      end else begin
         if (m_have && cyc >= m_first && cyc <= m_last && pg.stop) m_last = cyc;
         if ((!m_have || cyc >= m_last + LAT + 1) && pg.start) begin
            m_have  = 1'b1;
            m_first = cyc + 1;
            m_pi    = pg.phase_init;
            m_fw    = pg.freq_word;
            m_last  = (pg.burst_len == '0) ? BIG : m_first + int'(pg.burst_len) - 1;
         end
         cyc++;
      end
   end

   always @(negedge clk) begin : cmp
      bit in_run;
      in_run = m_have && cyc >= m_first && cyc <= m_last;
      if (in_run) m_hold = m_pi + m_fw * 32'(cyc - m_first);
      chk("angle_valid", 32'(pg.angle_valid), 32'(in_run));
      chk("angle", pg.angle, m_hold);
      chk("out_valid", 32'(pg.out_valid),
          32'(m_have && cyc >= m_first + LAT && cyc <= m_last + LAT));
      chk("busy", 32'(pg.busy), 32'(m_have && cyc >= m_first && cyc <= m_last + LAT));
      chk("done", 32'(pg.done), 32'(m_have && cyc == m_last + LAT + 1));
   end

   task automatic start_run(input logic [31:0] pi, input logic [31:0] fw,
                            input logic [15:0] bl, input logic stp);
      @(negedge clk);
      pg.phase_init = pi;
      pg.freq_word  = fw;
      pg.burst_len  = bl;
      pg.start      = 1'b1;
      pg.stop       = stp;
      @(negedge clk);
      pg.start = 1'b0;
      pg.stop  = 1'b0;
   endtask

   // Called in the last valid cycle; k = clocks until done is seen
   task automatic wait_done(output int k, output logic ov_at_lat);
      k = 0;
      ov_at_lat = 1'b0;
      do begin
         @(negedge clk);
         k++;
         pg.stop  = 1'b0;
         pg.start = 1'b0;
         if (k == LAT) ov_at_lat = pg.out_valid;
      end while (!pg.done && k < 60);
      if (!pg.done) chk("done_timeout", 32'(k), 32'(LAT + 1));
   endtask

   task automatic reset_pulse(input string tag);
      #2 nreset = 1'b0;
      #1;
      chk({tag, "_rst_angle"}, pg.angle, 32'h0);
      chk({tag, "_rst_av"}, 32'(pg.angle_valid), 32'h0);
      chk({tag, "_rst_ov"}, 32'(pg.out_valid), 32'h0);
      chk({tag, "_rst_busy"}, 32'(pg.busy), 32'h0);
      chk({tag, "_rst_done"}, 32'(pg.done), 32'h0);
      @(negedge clk);
      nreset = 1'b1;
   endtask

   task automatic burst1();
      int   k;
      logic ov;
      start_run(32'h0, 32'h2000_0000, 16'd8, 1'b0);
      chk("b1_first", pg.angle, 32'h0000_0000);
      repeat (7) @(negedge clk);
      chk("b1_last", pg.angle, 32'hE000_0000);
      chk("b1_last_av", 32'(pg.angle_valid), 32'h1);
      wait_done(k, ov);
      chk("b1_done_lat", 32'(k), 32'd17);
      chk("b1_ov_final", 32'(ov), 32'h1);
      chk("b1_hold", pg.angle, 32'hE000_0000);
   endtask

   initial begin
      int   k;
      logic ov;
      pg.start      = 1'b0;
      pg.stop       = 1'b0;
      pg.freq_word  = '0;
      pg.phase_init = '0;
      pg.burst_len  = '0;
      @(negedge clk);
      chk("reset_angle", pg.angle, 32'h0);
      chk("reset_busy", 32'(pg.busy), 32'h0);
      chk("reset_ov", 32'(pg.out_valid), 32'h0);
      nreset = 1'b1;

      burst1();

      start_run(32'hF000_0000, 32'h2000_0000, 16'd3, 1'b0);
      chk("wrap_a0", pg.angle, 32'hF000_0000);
      @(negedge clk);
      chk("wrap_a1", pg.angle, 32'h1000_0000);
      @(negedge clk);
      chk("wrap_a2", pg.angle, 32'h3000_0000);
      wait_done(k, ov);
      chk("wrap_done_lat", 32'(k), 32'd17);

      start_run(32'h0, 32'h0040_0000, 16'd0, 1'b0);
      repeat (5) @(negedge clk);
      chk("cont_last", pg.angle, 32'h0140_0000);
      pg.stop = 1'b1;
      wait_done(k, ov);
      chk("cont_done_lat", 32'(k), 32'd17);
      chk("cont_hold", pg.angle, 32'h0140_0000);

      start_run(32'h0, 32'h0100_0000, 16'd10, 1'b0);
      pg.freq_word  = 32'h1;
      pg.phase_init = 32'h55;
      pg.start      = 1'b1;
      @(negedge clk);
      pg.start = 1'b0;
      @(negedge clk);
      chk("mid_incr", pg.angle, 32'h0200_0000);
      k = 0;
      while (pg.angle_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("mid_run_len", 32'(k), 32'd8);
      @(negedge clk);
      pg.start = 1'b1;
      @(negedge clk);
      pg.start = 1'b0;
      wait_done(k, ov);
      @(negedge clk);
      chk("drain_start_ignored", 32'(pg.angle_valid), 32'h0);
      chk("drain_start_busy", 32'(pg.busy), 32'h0);

      start_run(32'h100, 32'h10, 16'd2, 1'b1);
      chk("startstop_av", 32'(pg.angle_valid), 32'h1);
      chk("startstop_a0", pg.angle, 32'h100);
      @(negedge clk);
      wait_done(k, ov);

      start_run(32'h0, 32'h2000_0000, 16'd8, 1'b0);
      repeat (3) @(negedge clk);
      reset_pulse("run");
      repeat (20) @(negedge clk);
      start_run(32'h0, 32'h2000_0000, 16'd4, 1'b0);
      repeat (6) @(negedge clk);
      chk("drain_busy", 32'(pg.busy), 32'h1);
      reset_pulse("drain");
      repeat (20) @(negedge clk);
      burst1();

      start_run(32'h0, 32'h2000_0000, 16'd2, 1'b0);
      @(negedge clk);
      k = 0;
      while (!pg.done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_done_seen", 32'(pg.done), 32'h1);
      pg.phase_init = 32'h4000_0000;
      pg.freq_word  = 32'h1;
      pg.burst_len  = 16'd2;
      pg.start      = 1'b1;
      @(negedge clk);
      pg.start = 1'b0;
      chk("b2b_av", 32'(pg.angle_valid), 32'h1);
      chk("b2b_a0", pg.angle, 32'h4000_0000);
      @(negedge clk);
      chk("b2b_a1", pg.angle, 32'h4000_0001);
      wait_done(k, ov);
      chk("b2b_done_lat", 32'(k), 32'd17);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
